// File: rtl/zeroriscy_instr_mem_pkg.sv
// Shared types and defaults for the instruction-fetch memory responder.
package zeroriscy_instr_mem_pkg;

  localparam int unsigned MEM_AW_DEF = 12;
  localparam int unsigned WAIT_W_DEF = 4;
  // Response countdown field width; WAIT_W may be anything up to this.
  localparam int unsigned DCNT_W     = 8;

  typedef enum logic [0:0] {
    G_IDLE,
    G_WAIT
  } gnt_state_e;

  typedef struct packed {
    logic [DCNT_W-1:0] dcnt;
    logic              dv;
    logic [31:0]       data;
  } resp_entry_t;

endpackage

// File: rtl/zeroriscy_instr_resp_queue.sv
// In-order response queue: each entry counts down its rvalid delay and
// captures SRAM data one cycle after it is pushed.
module zeroriscy_instr_resp_queue
  import zeroriscy_instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DCNT_W-1:0]            push_dcnt,
  input  logic [31:0]                  fill_data,
  input  logic                         pop,
  output resp_entry_t                  head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  resp_entry_t          entries_q [DEPTH];
  logic [DEPTH-1:0]     vld_q;
  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [CNT_W-1:0]     count_q;
  logic                 fill_pend_q;
  logic [PTR_W-1:0]     fill_idx_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fill_pend_q <= 1'b0;
      fill_idx_q  <= '0;
    end else begin
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= ptr_inc(head_q);
      end
      // A push into the slot being freed this cycle must win.
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= ptr_inc(tail_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      fill_pend_q <= push;
      fill_idx_q  <= tail_q;
    end
  end

  // NOTE: entry payloads are not reset; vld_q and the pointers alone decide
  // what is live, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld_q[i] && entries_q[i].dcnt != '0) begin
        entries_q[i].dcnt <= entries_q[i].dcnt - 1'b1;
      end
    end
    if (fill_pend_q) begin
      entries_q[fill_idx_q].dv   <= 1'b1;
      entries_q[fill_idx_q].data <= fill_data;
    end
    if (push) begin
      entries_q[tail_q] <= '{dcnt: push_dcnt, dv: 1'b0, data: 32'h0};
    end
  end

  assign head  = entries_q[head_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/zeroriscy_instr_mem_responder.sv
// Responder end of the instruction-fetch req/gnt/rvalid handshake in front of
// a single-cycle synchronous SRAM, with programmable grant and response delays.
module zeroriscy_instr_mem_responder
  import zeroriscy_instr_mem_pkg::*;
#(
  parameter int unsigned MEM_AW          = MEM_AW_DEF,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned WAIT_W          = WAIT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic [WAIT_W-1:0] cfg_gnt_wait_i,
  input  logic [WAIT_W-1:0] cfg_rvalid_wait_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  gnt_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              gnt;
  logic              pop;
  logic              room;
  logic [31:0]       rdata_q;
  logic [31:0]       pop_data;

  resp_entry_t       q_head;
  logic              q_empty;
  logic              q_full;
  logic [CNT_W-1:0]  q_count;

  logic              unused_addr;
  assign unused_addr = ^{instr_addr_i[31:MEM_AW+2], instr_addr_i[1:0]};

  // A response slot frees up in the same cycle the head is delivered.
  assign pop  = !q_empty && (q_head.dcnt == '0);
  assign room = !q_full || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= G_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // The IDLE cycle already counts as the first wait cycle, hence cfg-1.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      G_IDLE: begin
        if (instr_req_i && !gnt) begin
          state_d = G_WAIT;
          wcnt_d  = (cfg_gnt_wait_i == '0) ? '0 : cfg_gnt_wait_i - 1'b1;
        end
      end
      G_WAIT: begin
        if (!instr_req_i) begin
          state_d = G_IDLE;
          wcnt_d  = '0;
        end else if (gnt) begin
          state_d = G_IDLE;
        end else if (wcnt_q != '0) begin
          wcnt_d  = wcnt_q - 1'b1;
        end
      end
      default: state_d = G_IDLE;
    endcase
  end

  // Grant is combinational; rst_n gating keeps it low while reset is held.
  always_comb begin
    gnt = 1'b0;
    if (rst_n && instr_req_i && room) begin
      unique case (state_q)
        G_IDLE:  gnt = (cfg_gnt_wait_i == '0);
        G_WAIT:  gnt = (wcnt_q == '0);
        default: gnt = 1'b0;
      endcase
    end
  end

  zeroriscy_instr_resp_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gnt),
    .push_dcnt (DCNT_W'(cfg_rvalid_wait_i)),
    .fill_data (mem_rdata_i),
    .pop       (pop),
    .head      (q_head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  // A head granted last cycle has no stored data yet: bypass the SRAM output.
  assign pop_data = q_head.dv ? q_head.data : mem_rdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (pop) begin
      rdata_q <= pop_data;
    end
  end

  assign instr_gnt_o    = gnt;
  assign mem_req_o      = gnt;
  assign mem_addr_o     = instr_addr_i[MEM_AW+1:2];
  assign instr_rvalid_o = pop;
  assign instr_rdata_o  = pop ? pop_data : rdata_q;
  assign busy_o         = (state_q != G_IDLE) || (q_count != '0);

endmodule

// File: tb/tb_zeroriscy_instr_mem_responder.sv
// Directed bench for zeroriscy_instr_mem_responder with a behavioural SRAM.
module tb_zeroriscy_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        mem_req_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_rdata_i = '0;
  logic [3:0]  cfg_gnt_wait_i = '0;
  logic [3:0]  cfg_rvalid_wait_i = '0;
  logic        busy_o;

  logic [31:0] mem [4096];
  int total = 0;
  int bad   = 0;

  zeroriscy_instr_mem_responder #(
    .MEM_AW          (12),
    .MAX_OUTSTANDING (2),
    .WAIT_W          (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instr_req_i       (instr_req_i),
    .instr_addr_i      (instr_addr_i),
    .instr_gnt_o       (instr_gnt_o),
    .instr_rvalid_o    (instr_rvalid_o),
    .instr_rdata_o     (instr_rdata_o),
    .mem_req_o         (mem_req_o),
    .mem_addr_o        (mem_addr_o),
    .mem_rdata_i       (mem_rdata_i),
    .cfg_gnt_wait_i    (cfg_gnt_wait_i),
    .cfg_rvalid_wait_i (cfg_rvalid_wait_i),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req_o) mem_rdata_i <= mem[mem_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One cycle: drive after the edge, compare at the falling edge.
  task automatic cyc(input string tag, input logic [3:0] gw, input logic [3:0] rw,
                     input logic req, input logic [31:0] addr,
                     input logic eg, input logic ev, input logic [31:0] ed);
    @(posedge clk);
    #1;
    cfg_gnt_wait_i    = gw;
    cfg_rvalid_wait_i = rw;
    instr_req_i       = req;
    instr_addr_i      = addr;
    @(negedge clk);
    check({tag, ".gnt"}, instr_gnt_o, eg);
    check({tag, ".mem_req"}, mem_req_o, eg);
    check({tag, ".rvalid"}, instr_rvalid_o, ev);
    if (ev) check({tag, ".rdata"}, instr_rdata_o, ed);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h100 + i;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.gnt", instr_gnt_o, 0);
    check("rst.rvalid", instr_rvalid_o, 0);
    check("rst.rdata", instr_rdata_o, 0);
    check("rst.mem_req", mem_req_o, 0);
    check("rst.busy", busy_o, 0);
    rst_n = 1'b1;

    // Zero waits: back-to-back grants, bypassed responses one cycle later.
    cyc("z0", 0, 0, 1, 32'h0, 1, 0, 0);
    cyc("z1", 0, 0, 1, 32'h4, 1, 1, 32'h100);
    cyc("z2", 0, 0, 1, 32'h8, 1, 1, 32'h101);
    cyc("z3", 0, 0, 1, 32'hC, 1, 1, 32'h102);
    cyc("z4", 0, 0, 0, 32'h0, 0, 1, 32'h103);
    cyc("z5", 0, 0, 0, 32'h0, 0, 0, 0);
    check("z5.rdata_hold", instr_rdata_o, 32'h103);
    check("z5.busy", busy_o, 0);

    // Three wait states with an address redirect; last address wins.
    cyc("g0", 3, 0, 1, 32'h10, 0, 0, 0);
    cyc("g1", 3, 0, 1, 32'h10, 0, 0, 0);
    check("g1.busy", busy_o, 1);
    cyc("g2", 3, 0, 1, 32'h40, 0, 0, 0);
    cyc("g3", 3, 0, 1, 32'h40, 1, 0, 0);
    check("g3.mem_addr", mem_addr_o, 32'h10);
    cyc("g4", 0, 0, 0, 32'h0, 0, 1, 32'h110);

    // Response delay 2 with two outstanding: full queue stalls the third grant.
    cyc("f0", 0, 2, 1, 32'h0, 1, 0, 0);
    cyc("f1", 0, 2, 1, 32'h4, 1, 0, 0);
    cyc("f2", 0, 2, 1, 32'h8, 0, 0, 0);
    cyc("f3", 0, 2, 1, 32'h8, 1, 1, 32'h100);
    cyc("f4", 0, 2, 0, 32'h0, 0, 1, 32'h101);
    cyc("f5", 0, 2, 0, 32'h0, 0, 0, 0);
    cyc("f6", 0, 2, 0, 32'h0, 0, 1, 32'h102);

    // Short younger response must wait behind a long older one.
    cyc("o0", 0, 5, 1, 32'h20, 1, 0, 0);
    cyc("o1", 0, 0, 1, 32'h24, 1, 0, 0);
    for (int c = 2; c <= 5; c++) cyc($sformatf("o%0d", c), 0, 0, 0, 32'h0, 0, 0, 0);
    cyc("o6", 0, 0, 0, 32'h0, 0, 1, 32'h108);
    cyc("o7", 0, 0, 0, 32'h0, 0, 1, 32'h109);
    cyc("o8", 0, 0, 0, 32'h0, 0, 0, 0);

    // Initiator abort during a grant wait.
    cyc("a0", 4, 0, 1, 32'h30, 0, 0, 0);
    cyc("a1", 4, 0, 0, 32'h30, 0, 0, 0);
    cyc("a2", 4, 0, 0, 32'h30, 0, 0, 0);
    check("a2.busy", busy_o, 0);

    // Reset with two responses pending: they must vanish.
    cyc("r0", 0, 3, 1, 32'h0, 1, 0, 0);
    cyc("r1", 0, 3, 1, 32'h4, 1, 0, 0);
    cyc("r2", 0, 3, 0, 32'h0, 0, 0, 0);
    check("r2.busy", busy_o, 1);
    instr_req_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rr.gnt", instr_gnt_o, 0);
    check("rr.mem_req", mem_req_o, 0);
    check("rr.rvalid", instr_rvalid_o, 0);
    check("rr.rdata", instr_rdata_o, 0);
    check("rr.busy", busy_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    instr_req_i = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) cyc($sformatf("q%0d", c), 0, 0, 0, 32'h0, 0, 0, 0);
    check("q4.busy", busy_o, 0);
    // Upper and low address bits are ignored: 0x400B maps to word 2.
    cyc("n0", 0, 0, 1, 32'h0000_400B, 1, 0, 0);
    check("n0.mem_addr", mem_addr_o, 32'h2);
    cyc("n1", 0, 0, 0, 32'h0, 0, 1, 32'h102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
